// File: rtl/game_pkg.sv
// game_pkg: direction codes and move type shared by debouncer, move_queue and board engine
package game_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t       DIR_UP    = 2'd0;
    localparam dir_t       DIR_DOWN  = 2'd1;
    localparam dir_t       DIR_LEFT  = 2'd2;
    localparam dir_t       DIR_RIGHT = 2'd3;
    localparam logic [2:0] DIR_IDLE  = 3'd4;

    // codes 0..3 are moves, anything with bit 2 set is idle
    function automatic logic is_move(input logic [2:0] code);
        return !code[2];
    endfunction

endpackage

// File: rtl/move_queue.sv
// move_queue: show-ahead FIFO of debounced moves feeding the board engine (optional MOVE_QUEUE_STATS_EN adds drop counter)
module move_queue
    import game_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    in_dir,
    input  logic          clr,
    output logic          mv_valid,
    output dir_t          mv_dir,
    input  logic          mv_ready,
    output logic [CW-1:0] q_count,
    output logic          overflow,
    output logic [7:0]    drop_count
);

    localparam int AW = $clog2(DEPTH);

    dir_t          mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop, acc, drop;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push     = is_move(in_dir);
    assign pop      = mv_valid && mv_ready;
    assign acc      = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign mv_valid = !empty;
    assign mv_dir   = mem[rd_ptr[AW-1:0]];

    // pointers, occupancy and sticky overflow; clr wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + (AW+1)'(acc);
            rd_ptr   <= rd_ptr + (AW+1)'(pop);
            q_count  <= q_count + CW'(acc) - CW'(pop);
            overflow <= overflow || drop;
        end
    end

    // storage; a full-queue write lands in the slot the same-cycle pop vacates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
        end else if (acc && !clr) begin
            mem[wr_ptr[AW-1:0]] <= in_dir[1:0];
        end
    end

`ifdef MOVE_QUEUE_STATS_EN
    // saturating count of pushes lost to a full queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= 8'd0;
        else if (clr)
            drop_count <= 8'd0;
        else if (drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`else
    assign drop_count = 8'd0;
`endif

endmodule
